// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Main control FSM of the multi-cycle RV32I-subset core. Sequences
//            the shared ALU, unified memory port and register file.
//            Optional jalr support is compiled in with MCU_JALR_EN.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               zero,
   input  logic               neg,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [2:0]         ALUControl,
   output logic               RegWrite,
   output logic [1:0]         ImmSrc,
   output logic [STATE_W-1:0] state
);

   localparam logic [6:0] c_OP_LW   = 7'b0000011;
   localparam logic [6:0] c_OP_SW   = 7'b0100011;
   localparam logic [6:0] c_OP_R    = 7'b0110011;
   localparam logic [6:0] c_OP_I    = 7'b0010011;
   localparam logic [6:0] c_OP_B    = 7'b1100011;
   localparam logic [6:0] c_OP_JAL  = 7'b1101111;
   localparam logic [6:0] c_OP_JALR = 7'b1100111;

   localparam logic [2:0] c_ALU_ADD = 3'b000;
   localparam logic [2:0] c_ALU_SUB = 3'b001;
   localparam logic [2:0] c_ALU_AND = 3'b010;
   localparam logic [2:0] c_ALU_OR  = 3'b011;
   localparam logic [2:0] c_ALU_SLT = 3'b101;

   localparam logic [1:0] c_SRCA_PC    = 2'b00;
   localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
   localparam logic [1:0] c_SRCA_RD1   = 2'b10;
   localparam logic [1:0] c_SRCB_RD2   = 2'b00;
   localparam logic [1:0] c_SRCB_IMM   = 2'b01;
   localparam logic [1:0] c_SRCB_FOUR  = 2'b10;
   localparam logic [1:0] c_RES_ALUOUT = 2'b00;
   localparam logic [1:0] c_RES_DATA   = 2'b01;
   localparam logic [1:0] c_RES_ALURES = 2'b10;

   localparam logic [1:0] c_IMM_I = 2'b00;
   localparam logic [1:0] c_IMM_B = 2'b01;
   localparam logic [1:0] c_IMM_S = 2'b10;
   localparam logic [1:0] c_IMM_J = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
`ifdef MCU_JALR_EN
      S_JAL      = 4'd10,
      S_JALR     = 4'd11
`else
      S_JAL      = 4'd10
`endif
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [2:0] w_alu_funct;
   logic       w_taken;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   assign state = STATE_W'(r_state);

   // ALU operation for R/I execute; only register-register ops may select sub.
   always_comb begin
      w_alu_funct = c_ALU_ADD;
      case (funct3)
         3'b000:  w_alu_funct = ((op == c_OP_R) && funct7b5) ? c_ALU_SUB : c_ALU_ADD;
         3'b010:  w_alu_funct = c_ALU_SLT;
         3'b110:  w_alu_funct = c_ALU_OR;
         3'b111:  w_alu_funct = c_ALU_AND;
         default: w_alu_funct = c_ALU_ADD;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (funct3)
         3'b000:  w_taken = zero;
         3'b001:  w_taken = ~zero;
         3'b100:  w_taken = neg;
         3'b101:  w_taken = ~neg;
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      ImmSrc = c_IMM_I;
      case (op)
         c_OP_LW, c_OP_I, c_OP_JALR: ImmSrc = c_IMM_I;
         c_OP_B:                     ImmSrc = c_IMM_B;
         c_OP_SW:                    ImmSrc = c_IMM_S;
         c_OP_JAL:                   ImmSrc = c_IMM_J;
         default:                    ImmSrc = c_IMM_I;
      endcase
   end

   always_comb begin
      w_next     = S_FETCH;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = c_RES_ALUOUT;
      ALUSrcA    = c_SRCA_PC;
      ALUSrcB    = c_SRCB_RD2;
      ALUControl = c_ALU_ADD;
      RegWrite   = 1'b0;

      case (r_state)
         S_FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcB   = c_SRCB_FOUR;
            ResultSrc = c_RES_ALURES;
            w_next    = S_DECODE;
         end
         S_DECODE: begin
            // Precompute branch/jal target into ALUOut while decoding.
            ALUSrcA = c_SRCA_OLDPC;
            ALUSrcB = c_SRCB_IMM;
            case (op)
               c_OP_LW, c_OP_SW: w_next = S_MEMADR;
               c_OP_R:           w_next = S_EXECUTER;
               c_OP_I:           w_next = S_EXECUTEI;
               c_OP_B:           w_next = S_BRANCH;
               c_OP_JAL:         w_next = S_JAL;
`ifdef MCU_JALR_EN
               c_OP_JALR:        w_next = S_JALR;
`endif
               default:          w_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = c_SRCA_RD1;
            ALUSrcB = c_SRCB_IMM;
            if (op == c_OP_LW) begin
               w_next = S_MEMREAD;
            end else if (op == c_OP_SW) begin
               w_next = S_MEMWRITE;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_MEMREAD: begin
            AdrSrc    = 1'b1;
            ResultSrc = c_RES_ALUOUT;
            w_next    = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = c_RES_DATA;
            RegWrite  = 1'b1;
            w_next    = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            ResultSrc = c_RES_ALUOUT;
            MemWrite  = 1'b1;
            w_next    = S_FETCH;
         end
         S_EXECUTER: begin
            ALUSrcA    = c_SRCA_RD1;
            ALUSrcB    = c_SRCB_RD2;
            ALUControl = w_alu_funct;
            w_next     = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA    = c_SRCA_RD1;
            ALUSrcB    = c_SRCB_IMM;
            ALUControl = w_alu_funct;
            w_next     = S_ALUWB;
         end
         S_ALUWB: begin
            ResultSrc = c_RES_ALUOUT;
            RegWrite  = 1'b1;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA    = c_SRCA_RD1;
            ALUSrcB    = c_SRCB_RD2;
            ALUControl = c_ALU_SUB;
            ResultSrc  = c_RES_ALUOUT;
            PCWrite    = w_taken;
            w_next     = S_FETCH;
         end
         S_JAL: begin
            // PC <- ALUOut (target) while the ALU forms the link value OldPC+4.
            ALUSrcA   = c_SRCA_OLDPC;
            ALUSrcB   = c_SRCB_FOUR;
            ResultSrc = c_RES_ALUOUT;
            PCWrite   = 1'b1;
            w_next    = S_ALUWB;
         end
`ifdef MCU_JALR_EN
         S_JALR: begin
            ALUSrcA = c_SRCA_RD1;
            ALUSrcB = c_SRCB_IMM;
            w_next  = S_JAL;
         end
`endif
         default: begin
            w_next = S_FETCH;
         end
      endcase

      // Reset presents the FETCH selects with every write enable held off.
      if (reset) begin
         PCWrite    = 1'b0;
         IRWrite    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         AdrSrc     = 1'b0;
         ResultSrc  = c_RES_ALURES;
         ALUSrcA    = c_SRCA_PC;
         ALUSrcB    = c_SRCB_FOUR;
         ALUControl = c_ALU_ADD;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// Self-checking bench for multicycle_controller: directed instructions with
// literal traces, then randomized instructions against a sequence-level model.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, zero, neg;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .neg(neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .RegWrite(RegWrite), .ImmSrc(ImmSrc), .state(state)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                          JALR = 7'b1100111, UNK = 7'b1111111;

   typedef struct packed {
      logic       pcw, adr, mw, irw, rw;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
   } outs_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, z, n;
      bit         rand_zn;
      int         rst_at;
      string      lit;
      int         lit_alu;
      int         lit_pcw;
   } instr_t;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   int     m_seq[$];
   int     tr[$];
   int     alu_ex   = -1;
   int     pcw9     = -1;
   bit     running  = 1'b0;
   instr_t cur;
   instr_t dir[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   function automatic logic [2:0] alu_of(input bit is_r, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic taken(input logic [2:0] f3, input logic z, input logic n);
      case (f3)
         3'b000:  return z;
         3'b001:  return !z;
         3'b100:  return n;
         3'b101:  return !n;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      if (o == BR)  return 2'b01;
      if (o == SW)  return 2'b10;
      if (o == JAL) return 2'b11;
      return 2'b00;
   endfunction

   function automatic outs_t model_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                       input logic f7, input logic z, input logic n, input logic r);
      outs_t e;
      e = '0;
      case (r ? 0 : st)
         0:  begin e.irw = 1; e.pcw = 1; e.sb = 2; e.rs = 2; end
         1:  begin e.sa = 1; e.sb = 1; end
         2:  begin e.sa = 2; e.sb = 1; end
         3:  e.adr = 1;
         4:  begin e.rs = 1; e.rw = 1; end
         5:  begin e.adr = 1; e.mw = 1; end
         6:  begin e.sa = 2; e.alu = alu_of(1'b1, f3, f7); end
         7:  begin e.sa = 2; e.sb = 1; e.alu = alu_of(1'b0, f3, f7); end
         8:  e.rw = 1;
         9:  begin e.sa = 2; e.alu = 3'b001; e.pcw = taken(f3, z, n); end
         10: begin e.sa = 1; e.sb = 2; e.pcw = 1; end
         11: begin e.sa = 2; e.sb = 1; end
         default: e = '0;
      endcase
      if (r) begin
         e.pcw = 0; e.irw = 0; e.mw = 0; e.rw = 0;
      end
      e.imm = imm_of(o);
      return e;
   endfunction

   // Whole-instruction state walk, derived from the per-opcode latencies.
   task automatic build_seq(input logic [6:0] o);
      m_seq.delete();
      case (o)
         LW:      m_seq = {0, 1, 2, 3, 4};
         SW:      m_seq = {0, 1, 2, 5};
         RT:      m_seq = {0, 1, 6, 8};
         IT:      m_seq = {0, 1, 7, 8};
         BR:      m_seq = {0, 1, 9};
         JAL:     m_seq = {0, 1, 10, 8};
`ifdef MCU_JALR_EN
         JALR:    m_seq = {0, 1, 11, 10, 8};
`endif
         default: m_seq = {0, 1};
      endcase
   endtask

   function automatic int hexv(input byte c);
      return (c >= 8'h41) ? int'(c) - 55 : int'(c) - 48;
   endfunction

   function automatic instr_t mk(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic n, input int rst_at,
                                 input string lit, input int la, input int lp);
      instr_t t;
      t.op = o; t.f3 = f3; t.f7 = f7; t.z = z; t.n = n; t.rand_zn = 1'b0;
      t.rst_at = rst_at; t.lit = lit; t.lit_alu = la; t.lit_pcw = lp;
      return t;
   endfunction

   task automatic finish_instr();
      if (cur.lit.len() > 0) begin
         chk("trace_len", tr.size(), cur.lit.len());
         for (int i = 0; i < cur.lit.len() && i < tr.size(); i++)
            chk("trace_state", tr[i], hexv(cur.lit[i]));
      end
      if (cur.lit_alu >= 0) chk("exec_alucontrol", alu_ex, cur.lit_alu);
      if (cur.lit_pcw >= 0) chk("branch_pcwrite", pcw9, cur.lit_pcw);
      tr.delete();
      alu_ex = -1;
      pcw9   = -1;
   endtask

   always @(negedge clk) begin
      outs_t e;
      if (running && m_seq.size() > 0) begin
         e = model_out(m_seq[0], op, funct3, funct7b5, zero, neg, reset);
         chk("state",      int'(state),      m_seq[0]);
         chk("PCWrite",    int'(PCWrite),    int'(e.pcw));
         chk("AdrSrc",     int'(AdrSrc),     int'(e.adr));
         chk("MemWrite",   int'(MemWrite),   int'(e.mw));
         chk("IRWrite",    int'(IRWrite),    int'(e.irw));
         chk("RegWrite",   int'(RegWrite),   int'(e.rw));
         chk("ResultSrc",  int'(ResultSrc),  int'(e.rs));
         chk("ALUSrcA",    int'(ALUSrcA),    int'(e.sa));
         chk("ALUSrcB",    int'(ALUSrcB),    int'(e.sb));
         chk("ALUControl", int'(ALUControl), int'(e.alu));
         chk("ImmSrc",     int'(ImmSrc),     int'(e.imm));
         tr.push_back(int'(state));
         if (state == 4'd6 || state == 4'd7) alu_ex = int'(ALUControl);
         if (state == 4'd9) pcw9 = int'(PCWrite);
      end
   end

   initial begin
      logic [6:0] ops [8];
      int boot;
      int cidx;
      instr_t dummy;
      ops = '{LW, SW, RT, IT, BR, JAL, JALR, UNK};

      reset = 1'b1; op = UNK; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; neg = 1'b0;
      dummy = mk(UNK, 3'b000, 1'b0, 1'b0, 1'b0, -1, "", -1, -1);
      cur   = dummy;
      m_seq.push_back(0);
      boot  = 1;
      cidx  = 0;

      dir.push_back(mk(LW, 3'b010, 1'b0, 1'b0, 1'b0, -1, "01234", -1, -1));
      dir.push_back(mk(RT, 3'b000, 1'b1, 1'b0, 1'b0, -1, "0168", 1, -1));
      dir.push_back(mk(RT, 3'b111, 1'b0, 1'b0, 1'b0, -1, "0168", 2, -1));
      dir.push_back(mk(BR, 3'b001, 1'b0, 1'b0, 1'b0, -1, "019", -1, 1));
      dir.push_back(mk(BR, 3'b000, 1'b0, 1'b0, 1'b0, -1, "019", -1, 0));
      dir.push_back(mk(BR, 3'b101, 1'b0, 1'b0, 1'b1, -1, "019", -1, 0));
      dir.push_back(mk(SW, 3'b010, 1'b0, 1'b0, 1'b0, -1, "0125", -1, -1));
      dir.push_back(mk(SW, 3'b010, 1'b0, 1'b0, 1'b0, 2, "012", -1, -1));
`ifdef MCU_JALR_EN
      dir.push_back(mk(JALR, 3'b000, 1'b0, 1'b0, 1'b0, -1, "01BA8", -1, -1));
`else
      dir.push_back(mk(JALR, 3'b000, 1'b0, 1'b0, 1'b0, -1, "01", -1, -1));
`endif
      dir.push_back(mk(IT, 3'b000, 1'b1, 1'b0, 1'b0, -1, "0178", 0, -1));
      dir.push_back(mk(JAL, 3'b000, 1'b0, 1'b0, 1'b0, -1, "01A8", -1, -1));
      dir.push_back(mk(UNK, 3'b000, 1'b0, 1'b0, 1'b0, -1, "01", -1, -1));

      running = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (reset) begin
            finish_instr();
            m_seq.delete();
         end else begin
            void'(m_seq.pop_front());
            if (m_seq.size() == 0) finish_instr();
         end
         if (m_seq.size() == 0) begin
            if (boot > 0) begin
               cur = dummy;
            end else if (dir.size() > 0) begin
               cur = dir.pop_front();
            end else begin
               cur = mk(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
                        1'($urandom_range(0, 1)), 1'b0, 1'b0,
                        ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 4)) : -1,
                        "", -1, -1);
               if ($urandom_range(0, 4) == 0) cur.op = 7'($urandom_range(0, 127));
               cur.rand_zn = 1'b1;
            end
            op = cur.op; funct3 = cur.f3; funct7b5 = cur.f7;
            build_seq(cur.op);
            cidx = 0;
         end else begin
            cidx++;
         end
         if (boot > 0) begin
            reset = 1'b1;
            boot--;
         end else begin
            reset = (cidx == cur.rst_at);
         end
         zero = cur.rand_zn ? 1'($urandom_range(0, 1)) : cur.z;
         neg  = cur.rand_zn ? 1'($urandom_range(0, 1)) : cur.n;
      end
      @(negedge clk);
      #1;
      running = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
